serial_tx7: RTL and testbench
=============================

Name: serial_tx7

Overview:
Asynchronous-style serial transmitter that serializes a parallel data word onto a single line. Frame format, LSB first: start bit (0), DATA_W data bits, optional parity bit, stop bit (1). Sits at the output side of the lab datapath and is fed by the 7-bit parallel register stage. Pairs with a matching serial receiver at the far end of the line.

Parameters:
DATA_W, 7, data bits per frame (legal range 1..16)
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
tx_start  input  1  request to send tx_data; sampled on the rising edge of clk
tx_data  input  DATA_W  word to send; captured in the cycle tx_start is accepted
tx_ready  output  1  1 = idle, a tx_start will be accepted this cycle
tx_busy  output  1  1 = frame in progress
tx_done  output  1  one-cycle pulse, last cycle of the stop bit
tx  output  1  serial line; idles high

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, tick counter=0, shift register=0.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: tx=1. If tx_start=1, latch tx_data into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After DATA_W bits go to PARITY if enabled, otherwise STOP.
  - PARITY: parity bit for CLKS_PER_BIT cycles (see Optional Feature), then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Acceptance: tx_start is accepted at edge k only when state=IDLE.
- Latency from acceptance:
  - tx=0 and tx_busy=1 from cycle k+1.
  - tx_ready=0 from cycle k+1.
- Tick counter counts 0..CLKS_PER_BIT-1. The bit advances when the count reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- The bit counter wraps after DATA_W bits.
- Frame length, start of START through end of STOP:
  - Parity disabled: (DATA_W+2)*CLKS_PER_BIT cycles (144 with defaults).
  - Parity enabled: (DATA_W+3)*CLKS_PER_BIT cycles (160 with defaults).
- tx_done=1 only in the final cycle of STOP. In the next cycle tx_busy=0 and tx_ready=1.
- Back-to-back frames: a tx_start held high, or asserted in the first IDLE cycle, starts the next frame. Minimum gap is 1 idle cycle (tx=1).
- tx_start while busy is ignored: no queueing, and the frame in flight is unaffected.
- Changes on tx_data after acceptance do not affect the frame in flight.
- Reset mid-frame returns immediately to the reset values; tx goes high asynchronously. No partial frame resumes after reset is released.
- Invariant: tx_ready = ~tx_busy at all times.

Optional Feature:
Macro: SERIAL_TX7_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - The parity bit is even parity: XOR of the latched data bits, so the total count of 1s in data+parity is even.
  - Frame length grows by CLKS_PER_BIT.
- Undefined: the PARITY state and its logic are absent; STOP follows the last data bit directly.
- Port list is identical in both builds.

Test Plan:
1. Reset then idle: assert reset for 3 cycles, release, run 50 cycles -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
2. Single frame, tx_data=7'h55, CLKS_PER_BIT=16, no parity:
   - From cycle k+1, tx is 0 for 16 cycles, then bits 1,0,1,0,1,0,1 for 16 cycles each, then 1 for 16 cycles.
   - tx_done pulses exactly once, at cycle k+144.
   - tx_ready returns to 1 at cycle k+145.
3. Busy rejection: start frame with 7'h7F; at cycle k+40 pulse tx_start with tx_data=7'h00 -> serialized bits remain all-1 data, exactly one tx_done, no second frame starts.
4. Back-to-back: hold tx_start=1 with 7'h01 then 7'h40 -> two complete frames separated by exactly one idle-high cycle. The LSB of the first frame's data is 1; the MSB of the second frame's data is 1.
5. Reset mid-frame: reset asserted at cycle k+70 of a 7'h2A frame -> tx=1 and tx_ready=1 within that cycle, no tx_done. A later frame of 7'h15 transmits correctly.
6. Parity build (SERIAL_TX7_PARITY_EN): 7'h07 -> parity bit 1; 7'h03 -> parity bit 0. Frame length is 160 cycles.

Source files
------------

// File: rtl/serial_tx7.sv
// Serial transmitter that sends a frame LSB first: start bit, DATA_W data bits, optional parity, stop bit.
// Define SERIAL_TX7_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module serial_tx7 #(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_TX7_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef SERIAL_TX7_PARITY_EN
  logic                par_q, par_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX7_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef SERIAL_TX7_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef SERIAL_TX7_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (tick_q == TICK_LAST);

    if (state_q != ST_IDLE) begin
      tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          shift_d = tx_data;
`ifdef SERIAL_TX7_PARITY_EN
          // Parity is taken at capture time because the shift register is consumed as bits go out.
          par_d   = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
`ifdef SERIAL_TX7_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef SERIAL_TX7_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next-state values so they line up with the state they describe.
    busy_d  = (state_d != ST_IDLE);
    ready_d = ~busy_d;
    done_d  = (state_d == ST_STOP) && (tick_d == TICK_LAST);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX7_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_serial_tx7.sv
// Bench for serial_tx7: frame-level reference model compared every cycle, plus pinned literal checks.
// Build with SERIAL_TX7_PARITY_EN defined to exercise the parity frame.
module tb_serial_tx7;

  localparam int DATA_W = 7;
  localparam int CPB    = 16;
`ifdef SERIAL_TX7_PARITY_EN
  localparam int FLEN = (DATA_W + 3) * CPB;
`else
  localparam int FLEN = (DATA_W + 2) * CPB;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tx_start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready, tx_busy, tx_done, tx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;

  // Reference model: a frame is active for FLEN cycles after acceptance; m_pos is the cycle within it.
  logic              m_active = 1'b0;
  int                m_pos = 0;
  logic [DATA_W-1:0] m_data = '0;

  logic e_tx, e_busy, e_done;
  int   d0;

  serial_tx7 #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
    end else if (!m_active) begin
      if (tx_start) begin
        m_active <= 1'b1;
        m_pos    <= 0;
        m_data   <= tx_data;
      end
    end else if (m_pos == FLEN - 1) begin
      m_active <= 1'b0;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  // Bit slot idx of a frame: 0 start, 1..DATA_W data LSB first, then parity (if built), then stop.
  function automatic logic exp_bit(input int idx, input logic [DATA_W-1:0] d);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return d[idx-1];
`ifdef SERIAL_TX7_PARITY_EN
    if (idx == DATA_W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Returns at the sample point of cycle k+1, where edge k accepted the word.
  task automatic send(input logic [DATA_W-1:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          e_busy = m_active;
          e_tx   = m_active ? exp_bit(m_pos / CPB, m_data) : 1'b1;
          e_done = m_active && (m_pos == FLEN - 1);
          chk("cmp_tx", 32'(tx), 32'(e_tx));
          chk("cmp_busy", 32'(tx_busy), 32'(e_busy));
          chk("cmp_ready", 32'(tx_ready), 32'(!e_busy));
          chk("cmp_done", 32'(tx_done), 32'(e_done));
        end else begin
          chk("rst_tx", 32'(tx), 32'(1));
          chk("rst_ready", 32'(tx_ready), 32'(1));
          chk("rst_busy", 32'(tx_busy), 32'(0));
          chk("rst_done", 32'(tx_done), 32'(0));
        end
        if (tx_done === 1'b1) done_cnt++;
      end

      begin
        // Reset then idle
        wait_n(3);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          chk("idle_tx", 32'(tx), 32'(1));
          chk("idle_ready", 32'(tx_ready), 32'(1));
          chk("idle_busy", 32'(tx_busy), 32'(0));
          chk("idle_done", 32'(tx_done), 32'(0));
        end

        // Single frame of 0x55
        d0 = done_cnt;
        send(7'h55);
        chk("f55_start_tx", 32'(tx), 32'(0));
        chk("f55_start_busy", 32'(tx_busy), 32'(1));
        chk("f55_start_ready", 32'(tx_ready), 32'(0));
        wait_n(24);
        chk("f55_bit0", 32'(tx), 32'(1));
        wait_n(16);
        chk("f55_bit1", 32'(tx), 32'(0));
        wait_n(FLEN - 1 - 41);
        chk("f55_done_early", 32'(tx_done), 32'(0));
        wait_n(1);
        chk("f55_done", 32'(tx_done), 32'(1));
        chk("f55_stop_tx", 32'(tx), 32'(1));
        wait_n(1);
        chk("f55_ready_back", 32'(tx_ready), 32'(1));
        chk("f55_done_off", 32'(tx_done), 32'(0));
        chk("f55_done_count", 32'(done_cnt - d0), 32'(1));
        wait_n(5);

        // Busy rejection
        d0 = done_cnt;
        send(7'h7F);
        wait_n(39);
        tx_data  = 7'h00;
        tx_start = 1'b1;
        wait_n(1);
        tx_start = 1'b0;
        wait_n(80);
        chk("rej_bit6", 32'(tx), 32'(1));
        wait_n(FLEN + 20 - 121);
        chk("rej_done_count", 32'(done_cnt - d0), 32'(1));
        chk("rej_no_second", 32'(tx_busy), 32'(0));

        // Back-to-back with tx_start held
        d0 = done_cnt;
        tx_data  = 7'h01;
        tx_start = 1'b1;
        wait_n(1);
        tx_data = 7'h40;
        wait_n(24);
        chk("b2b_lsb", 32'(tx), 32'(1));
        wait_n(FLEN + 1 - 25);
        chk("b2b_gap_tx", 32'(tx), 32'(1));
        chk("b2b_gap_busy", 32'(tx_busy), 32'(0));
        wait_n(1);
        chk("b2b_second_start", 32'(tx), 32'(0));
        chk("b2b_second_busy", 32'(tx_busy), 32'(1));
        tx_start = 1'b0;
        wait_n(120);
        chk("b2b_msb", 32'(tx), 32'(1));
        wait_n(FLEN);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'(2));

        // Reset mid-frame
        d0 = done_cnt;
        send(7'h2A);
        wait_n(69);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'(1));
        chk("mid_rst_ready", 32'(tx_ready), 32'(1));
        chk("mid_rst_busy", 32'(tx_busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        wait_n(200);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'(0));
        send(7'h15);
        wait_n(24);
        chk("f15_bit0", 32'(tx), 32'(1));
        wait_n(16);
        chk("f15_bit1", 32'(tx), 32'(0));
        wait_n(FLEN);
        chk("f15_done_count", 32'(done_cnt - d0), 32'(1));

`ifdef SERIAL_TX7_PARITY_EN
        // Parity bits and frame length
        d0 = done_cnt;
        send(7'h07);
        wait_n(135);
        chk("par07", 32'(tx), 32'(1));
        wait_n(FLEN - 136);
        chk("par07_done_160", 32'(tx_done), 32'(1));
        wait_n(5);
        send(7'h03);
        wait_n(135);
        chk("par03", 32'(tx), 32'(0));
        wait_n(FLEN - 136);
        chk("par03_done_160", 32'(tx_done), 32'(1));
        wait_n(5);
        chk("par_done_count", 32'(done_cnt - d0), 32'(2));
`endif

        // Randomized traffic with data churn, busy-time starts and occasional resets
        d0 = done_cnt;
        for (int i = 0; i < 5000; i++) begin
          tx_start = ($urandom % 8) == 0;
          tx_data  = DATA_W'($urandom);
          if (reset) reset = 1'b0;
          else if (($urandom % 1200) == 0) reset = 1'b1;
          @(negedge clk);
        end
        tx_start = 1'b0;
        reset    = 1'b0;
        wait_n(FLEN + 5);
        chk("rand_frames", 32'(done_cnt - d0 >= 10), 32'(1));
        chk("rand_final_idle", 32'(tx_busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join
  end

endmodule
